// File: rtl/gr8ram_sdram_pkg.sv
// SDRAM command encodings, slot phase numbers and init-state type for the GR8RAM scheduler.
// Latency: n/a (constants and one helper only).
// Backpressure: n/a.
package gr8ram_sdram_pkg;

   // {nRCS, nRAS, nCAS, nSWE}
   localparam logic [3:0] CMD_NOP   = 4'b1111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_RD    = 4'b0101;
   localparam logic [3:0] CMD_WR    = 4'b0100;
   localparam logic [3:0] CMD_PCALL = 4'b0010;
   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam logic [3:0] CMD_LDM   = 4'b0000;

   // Phase in which each command is decided; it reaches the pins one cycle later.
   localparam logic [3:0] PH_ACT = 4'd1;
   localparam logic [3:0] PH_RD  = 4'd2;
   localparam logic [3:0] PH_CAP = 4'd5;
   localparam logic [3:0] PH_WR  = 4'd8;
   localparam logic [3:0] PH_PC  = 4'd10;
   localparam logic [3:0] PH_REF = 4'd11;

   // CAS latency 2, burst length 1, single-location write bursts.
   localparam logic [12:0] MODE_WORD = 13'h0220;
   // A10 high selects all banks for precharge.
   localparam logic [12:0] SA_PCALL  = 13'h0400;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_PCLM,
      ST_AREF,
      ST_RUN
   } init_st_t;

   // Column address with A10 set so every RD/WR auto-precharges.
   function automatic logic [12:0] col_sa(input logic [8:0] col);
      return {4'b0011, col};
   endfunction

endpackage

// File: rtl/sdram_ref_ctr.sv
// Refresh credit tracker: REF_DIV prescaler on Apple-cycle ticks feeding a saturating owed count.
// Latency: owed changes on the clock edge after a tick or dec pulse.
// Backpressure: none; a tick and a dec in the same cycle cancel, dec at zero is dropped.
module sdram_ref_ctr #(
   parameter logic [3:0] REF_DIV = 4'd4,
   parameter logic [2:0] REF_MAX = 3'd7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       dec,
   output logic [2:0] owed
);

   logic [3:0] div_cnt;
   logic       inc;

   assign inc = tick && (div_cnt == REF_DIV - 4'd1);

   // Prescaler: one credit every REF_DIV Apple cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_cnt <= 4'd0;
      else if (tick)
         div_cnt <= inc ? 4'd0 : div_cnt + 4'd1;
   end

   // Owed count: saturate at REF_MAX, floor at zero, simultaneous inc/dec leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         owed <= 3'd0;
      else if (inc && !dec && (owed != REF_MAX))
         owed <= owed + 3'd1;
      else if (dec && !inc && (owed != 3'd0))
         owed <= owed - 3'd1;
   end

endmodule

// File: rtl/sdram_slot_sched.sv
// GR8RAM SDRAM scheduler: 16-phase sequence per PHI0 rise, shared ACT/RD/WR slot, refresh, power-up init.
// Latency: command decided at PS==N is on the pins during PS==N+1; read data valid during PS==6.
// Backpressure: loader request is a level held until ld_gnt; bus wins ties. Macro SDRAM_CKE_GATE_EN gates RCKE.
module sdram_slot_sched
   import gr8ram_sdram_pkg::*;
#(
   parameter logic [15:0] INIT_WAIT = 16'd8142,
   parameter logic [3:0]  INIT_AREF = 4'd8,
   parameter logic [3:0]  REF_DIV   = 4'd4,
   parameter logic [2:0]  REF_MAX   = 3'd7
) (
   input  logic        C25M,
   input  logic        nRES,
   input  logic        PHI0,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [23:0] bus_addr,
   input  logic        ld_req,
   input  logic [23:0] ld_addr,
   input  logic [7:0]  SD,
   output logic        RCKE,
   output logic [3:0]  sd_cmd,
   output logic [1:0]  SBA,
   output logic [12:0] SA,
   output logic        DQML,
   output logic        DQMH,
   output logic        SDOE,
   output logic        wr_sel,
   output logic        bus_gnt,
   output logic        ld_gnt,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic [3:0]  PS,
   output logic        init_done
);

   logic [2:0]  phi_sync;
   logic        start;
   logic [3:0]  ps_nx;
   init_st_t    st;
   logic [15:0] init_cnt;
   logic        run;
   logic        slot, owner_we, ref_now, ref_dec;
   logic [23:0] owner_addr, win_addr;
   logic        win_bus, win_ld;
   logic [2:0]  owed;
   logic [3:0]  cmd_n;
   logic [1:0]  sba_n;
   logic [12:0] sa_n;
   logic        dqml_n, dqmh_n, sdoe_n;

   assign run      = (st == ST_RUN);
   assign start    = phi_sync[1] & ~phi_sync[2] & (PS == 4'd0);
   assign ps_nx    = (PS == 4'd0) ? {3'd0, start} : PS + 4'd1;
   assign win_bus  = run && (PS == PH_ACT) && bus_req;
   assign win_ld   = run && (PS == PH_ACT) && !bus_req && ld_req;
   assign win_addr = bus_req ? bus_addr : ld_addr;
   assign ref_dec  = (PS == PH_REF) && ref_now;

   sdram_ref_ctr #(.REF_DIV(REF_DIV), .REF_MAX(REF_MAX)) u_ref (
      .clk   (C25M),
      .rst_n (nRES),
      .tick  (start),
      .dec   (ref_dec),
      .owed  (owed)
   );

   // Next command/address for the pins, chosen by phase and init state.
   always_comb begin
      cmd_n  = CMD_NOP;
      sba_n  = 2'b00;
      sa_n   = 13'd0;
      dqml_n = 1'b1;
      dqmh_n = 1'b1;
      sdoe_n = 1'b0;
      case (PS)
         PH_ACT: if (win_bus || win_ld) begin
            cmd_n = CMD_ACT;
            sba_n = {1'b0, win_addr[23]};
            sa_n  = win_addr[22:10];
         end
         PH_RD: if (slot && !owner_we) begin
            cmd_n  = CMD_RD;
            sba_n  = {1'b0, owner_addr[23]};
            sa_n   = col_sa(owner_addr[9:1]);
            dqml_n = owner_addr[0];
            dqmh_n = ~owner_addr[0];
         end
         PH_WR: if (slot && owner_we) begin
            cmd_n  = CMD_WR;
            sba_n  = {1'b0, owner_addr[23]};
            sa_n   = col_sa(owner_addr[9:1]);
            dqml_n = owner_addr[0];
            dqmh_n = ~owner_addr[0];
            sdoe_n = 1'b1;
         end
         PH_PC: if ((st == ST_PCLM) || (run && (owed != 3'd0))) begin
            cmd_n = CMD_PCALL;
            sa_n  = SA_PCALL;
         end
         PH_REF: if (st == ST_PCLM) begin
            cmd_n = CMD_LDM;
            sa_n  = MODE_WORD;
         end else if ((st == ST_AREF) || ref_now) begin
            cmd_n = CMD_AREF;
         end
         default: ;
      endcase
   end

`ifdef SDRAM_CKE_GATE_EN
   logic cke_pre;
   // Clock enable must also be up in the cycle before any phase that may decide a command.
   always_comb begin
      cke_pre = ps_nx inside {PH_ACT, PH_RD, PH_WR, PH_PC, PH_REF};
   end
`endif

   // Synchronize PHI0 and keep one extra stage for rise detection.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) phi_sync <= 3'b000;
      else       phi_sync <= {phi_sync[1:0], PHI0};
   end

   // Phase counter: parked at 0 until a PHI0 rise, then free-runs back to 0.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) PS <= 4'd0;
      else       PS <= ps_nx;
   end

   // Registered SDRAM pins.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         RCKE   <= 1'b1;
         sd_cmd <= CMD_NOP;
         SBA    <= 2'b00;
         SA     <= 13'd0;
         DQML   <= 1'b1;
         DQMH   <= 1'b1;
         SDOE   <= 1'b0;
      end else begin
`ifdef SDRAM_CKE_GATE_EN
         RCKE   <= (cmd_n != CMD_NOP) || cke_pre;
`else
         RCKE   <= 1'b1;
`endif
         sd_cmd <= cmd_n;
         SBA    <= sba_n;
         SA     <= sa_n;
         DQML   <= dqml_n;
         DQMH   <= dqmh_n;
         SDOE   <= sdoe_n;
      end
   end

   // Slot ownership, grants, read capture and refresh-in-progress flag.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         slot       <= 1'b0;
         owner_addr <= 24'd0;
         owner_we   <= 1'b0;
         wr_sel     <= 1'b0;
         bus_gnt    <= 1'b0;
         ld_gnt     <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= 8'd0;
         ref_now    <= 1'b0;
      end else begin
         bus_gnt <= win_bus;
         ld_gnt  <= win_ld;
         if (PS == PH_ACT) begin
            slot       <= win_bus || win_ld;
            owner_addr <= win_addr;
            owner_we   <= win_ld || bus_we;
            wr_sel     <= win_ld;
         end else if (PS == 4'd15) begin
            slot <= 1'b0;
         end
         rd_valid <= (PS == PH_CAP) && slot && !owner_we;
         if ((PS == PH_CAP) && slot && !owner_we)
            rd_data <= SD;
         ref_now <= (PS == PH_PC) && run && (owed != 3'd0);
      end
   end

   // Power-up init FSM, advancing once per Apple cycle at its last phase.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         st        <= ST_WAIT;
         init_cnt  <= 16'd0;
         init_done <= 1'b0;
      end else if (PS == 4'd15) begin
         case (st)
            ST_WAIT:
               if (init_cnt == INIT_WAIT - 16'd1) begin
                  st       <= ST_PCLM;
                  init_cnt <= 16'd0;
               end else begin
                  init_cnt <= init_cnt + 16'd1;
               end
            ST_PCLM: begin
               st       <= ST_AREF;
               init_cnt <= 16'd0;
            end
            ST_AREF:
               if (init_cnt == {12'd0, INIT_AREF - 4'd1}) begin
                  st        <= ST_RUN;
                  init_done <= 1'b1;
                  init_cnt  <= 16'd0;
               end else begin
                  init_cnt <= init_cnt + 16'd1;
               end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_slot_sched.sv
// Directed bench for sdram_slot_sched: init, refresh, read, arbitration, PHI0 restart guard, mid-write reset.
// Latency: each Apple cycle is recorded phase by phase and checked afterwards.
// Backpressure: loader request held until its grant is observed.
module tb_sdram_slot_sched;
   import gr8ram_sdram_pkg::*;

   logic        C25M = 1'b0;
   logic        nRES, PHI0, bus_req, bus_we, ld_req;
   logic [23:0] bus_addr, ld_addr;
   logic [7:0]  SD;
   logic        RCKE, DQML, DQMH, SDOE, wr_sel, bus_gnt, ld_gnt, rd_valid, init_done;
   logic [3:0]  sd_cmd, PS;
   logic [1:0]  SBA;
   logic [12:0] SA;
   logic [7:0]  rd_data;

   int checks = 0;
   int errors = 0;

   logic [3:0]  cmd_at [16];
   logic [12:0] sa_at  [16];
   logic [1:0]  sba_at [16];
   logic [1:0]  dqm_at [16];
   logic        sdoe_at[16], wrsel_at[16], bg_at[16], lg_at[16], rv_at[16], done_at[16];
   logic [7:0]  rd_at  [16];
   logic [7:0]  sd_drive;
   logic        rephi;

   sdram_slot_sched #(
      .INIT_WAIT (16'd40),
      .INIT_AREF (4'd8),
      .REF_DIV   (4'd4),
      .REF_MAX   (3'd7)
   ) dut (
      .C25M(C25M), .nRES(nRES), .PHI0(PHI0), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .ld_req(ld_req), .ld_addr(ld_addr), .SD(SD),
      .RCKE(RCKE), .sd_cmd(sd_cmd), .SBA(SBA), .SA(SA), .DQML(DQML), .DQMH(DQMH),
      .SDOE(SDOE), .wr_sel(wr_sel), .bus_gnt(bus_gnt), .ld_gnt(ld_gnt),
      .rd_data(rd_data), .rd_valid(rd_valid), .PS(PS), .init_done(init_done)
   );

   always #20 C25M = ~C25M;

   task automatic snap(input int i);
      cmd_at[i]   = sd_cmd;
      sa_at[i]    = SA;
      sba_at[i]   = SBA;
      dqm_at[i]   = {DQML, DQMH};
      sdoe_at[i]  = SDOE;
      wrsel_at[i] = wr_sel;
      bg_at[i]    = bus_gnt;
      lg_at[i]    = ld_gnt;
      rv_at[i]    = rd_valid;
      done_at[i]  = init_done;
      rd_at[i]    = rd_data;
   endtask

   // One Apple cycle: raise PHI0, record every phase 1..15 and the following PS==0.
   task automatic run_cycle;
      int n;
      n = 0;
      PHI0 = 1'b1;
      @(negedge C25M);
      while (PS !== 4'd1 && n < 8) begin
         @(negedge C25M);
         n++;
      end
      checks++;
      if (PS !== 4'd1) begin
         errors++;
         $display("FAIL cycle_start: PS=%0d, required 1", PS);
      end
      PHI0 = 1'b0;
      snap(1);
      for (int p = 2; p <= 16; p++) begin
         logic [3:0] exp_ps;
         exp_ps = p[3:0];
         @(negedge C25M);
         checks++;
         if (PS !== exp_ps) begin
            errors++;
            $display("FAIL ps_seq: PS=%0d, required %0d", PS, exp_ps);
         end
         snap(int'(exp_ps));
         if (p == 5) SD = sd_drive;
         if (p == 6) begin
            SD = 8'h00;
            if (rephi) PHI0 = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({PS, sd_cmd, SBA, SA, DQML, DQMH, SDOE, RCKE} !== {4'd0, 4'hF, 2'd0, 13'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_pins: PS=%h cmd=%h SBA=%h SA=%h DQM=%b%b SDOE=%b RCKE=%b", PS, sd_cmd, SBA, SA, DQML, DQMH, SDOE, RCKE);
      end
      nRES = 1'b1;
      repeat (2) @(negedge C25M);
      checks++;
      if ({wr_sel, bus_gnt, ld_gnt, rd_valid, init_done, rd_data} !== 13'd0) begin
         errors++;
         $display("FAIL reset_flags: wr_sel=%b bg=%b lg=%b rv=%b done=%b rd=%h, required all 0",
                  wr_sel, bus_gnt, ld_gnt, rd_valid, init_done, rd_data);
      end
      checks++;
      if (PS !== 4'd0 || sd_cmd !== CMD_NOP) begin
         errors++;
         $display("FAIL reset_idle: PS=%0d cmd=%h, required 0/F", PS, sd_cmd);
      end
   endtask

   task automatic test_init;
      int n_ldm, n_aref, n_pc, n_act, n_gnt;
      logic [12:0] ldm_sa;
      logic done48;
      n_ldm = 0; n_aref = 0; n_pc = 0; n_act = 0; n_gnt = 0;
      ldm_sa = 13'd0; done48 = 1'b1;
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 24'h812345;
      ld_req = 1'b1; ld_addr = 24'h000400;
      for (int c = 1; c <= 49; c++) begin
         run_cycle();
         for (int i = 0; i < 16; i++) begin
            if (cmd_at[i] === CMD_LDM) begin n_ldm++; ldm_sa = sa_at[i]; end
            if (cmd_at[i] === CMD_AREF) n_aref++;
            if (cmd_at[i] === CMD_PCALL) n_pc++;
            if (cmd_at[i] === CMD_ACT) n_act++;
            if (bg_at[i] === 1'b1 || lg_at[i] === 1'b1) n_gnt++;
         end
         if (c == 48) done48 = done_at[0];
      end
      bus_req = 1'b0; ld_req = 1'b0;
      checks++; if (n_ldm != 1) begin errors++; $display("FAIL init_ldm_count: %0d, required 1", n_ldm); end
      checks++; if (ldm_sa !== MODE_WORD) begin errors++; $display("FAIL init_ldm_sa: %h, required 0220", ldm_sa); end
      checks++; if (n_aref != 8) begin errors++; $display("FAIL init_aref_count: %0d, required 8", n_aref); end
      checks++; if (n_pc != 1) begin errors++; $display("FAIL init_pc_count: %0d, required 1", n_pc); end
      checks++; if (n_act != 0 || n_gnt != 0) begin errors++; $display("FAIL init_no_grant: act=%0d gnt=%0d, required 0/0", n_act, n_gnt); end
      checks++; if (done48 !== 1'b0) begin errors++; $display("FAIL init_done_early: %b, required 0", done48); end
      checks++; if (done_at[15] !== 1'b0 || done_at[0] !== 1'b1) begin
         errors++; $display("FAIL init_done_edge: ps15=%b ps0=%b, required 0/1", done_at[15], done_at[0]);
      end
   endtask

   // Owed enters RUN saturated at 7; credits land at RUN cycles 3, 7 and 11.
   task automatic test_refresh;
      logic [10:0] exp_ref;
      exp_ref = 11'b101_1111_1111;
      for (int k = 0; k < 11; k++) begin
         run_cycle();
         checks++;
         if (cmd_at[11] !== (exp_ref[k] ? CMD_PCALL : CMD_NOP)) begin
            errors++; $display("FAIL refresh_pc[%0d]: cmd=%h, required %h", k, cmd_at[11], exp_ref[k] ? CMD_PCALL : CMD_NOP);
         end
         checks++;
         if (cmd_at[12] !== (exp_ref[k] ? CMD_AREF : CMD_NOP)) begin
            errors++; $display("FAIL refresh_aref[%0d]: cmd=%h, required %h", k, cmd_at[12], exp_ref[k] ? CMD_AREF : CMD_NOP);
         end
         checks++;
         if (sa_at[11] !== (exp_ref[k] ? SA_PCALL : 13'd0)) begin
            errors++; $display("FAIL refresh_sa[%0d]: SA=%h", k, sa_at[11]);
         end
      end
   endtask

   task automatic test_read;
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 24'h812345; sd_drive = 8'h5A;
      run_cycle();
      bus_req = 1'b0; sd_drive = 8'h00;
      checks++; if (bg_at[2] !== 1'b1 || lg_at[2] !== 1'b0) begin errors++; $display("FAIL read_gnt: bg=%b lg=%b, required 1/0", bg_at[2], lg_at[2]); end
      checks++; if (cmd_at[2] !== CMD_ACT || sba_at[2] !== 2'b01 || sa_at[2] !== 13'h0048) begin
         errors++; $display("FAIL read_act: cmd=%h SBA=%b SA=%h, required 3/01/0048", cmd_at[2], sba_at[2], sa_at[2]);
      end
      checks++; if (cmd_at[3] !== CMD_RD || sba_at[3] !== 2'b01 || sa_at[3] !== 13'h07A2 || dqm_at[3] !== 2'b10) begin
         errors++; $display("FAIL read_rd: cmd=%h SBA=%b SA=%h DQM=%b, required 5/01/07A2/10", cmd_at[3], sba_at[3], sa_at[3], dqm_at[3]);
      end
      checks++; if (cmd_at[4] !== CMD_NOP || sa_at[4] !== 13'd0 || dqm_at[4] !== 2'b11) begin
         errors++; $display("FAIL read_idle: cmd=%h SA=%h DQM=%b, required F/0/11", cmd_at[4], sa_at[4], dqm_at[4]);
      end
      checks++; if (rv_at[5] !== 1'b0 || rv_at[6] !== 1'b1 || rv_at[7] !== 1'b0) begin
         errors++; $display("FAIL read_valid: ps5=%b ps6=%b ps7=%b, required 0/1/0", rv_at[5], rv_at[6], rv_at[7]);
      end
      checks++; if (rd_at[6] !== 8'h5A) begin errors++; $display("FAIL read_data: %h, required 5A", rd_at[6]); end
      checks++; if (cmd_at[9] !== CMD_NOP || sdoe_at[9] !== 1'b0) begin errors++; $display("FAIL read_no_wr: cmd=%h SDOE=%b", cmd_at[9], sdoe_at[9]); end
   endtask

   task automatic test_back_to_back;
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 24'h000001;
      ld_req = 1'b1; ld_addr = 24'h000400;
      run_cycle();
      bus_req = 1'b0;
      checks++; if (bg_at[2] !== 1'b1 || lg_at[2] !== 1'b0) begin errors++; $display("FAIL arb_bus_wins: bg=%b lg=%b, required 1/0", bg_at[2], lg_at[2]); end
      checks++; if (cmd_at[9] !== CMD_WR || sdoe_at[9] !== 1'b1 || wrsel_at[9] !== 1'b0 || dqm_at[9] !== 2'b10 || sa_at[9] !== 13'h0600) begin
         errors++; $display("FAIL bus_wr: cmd=%h SDOE=%b wr_sel=%b DQM=%b SA=%h, required 4/1/0/10/0600",
                            cmd_at[9], sdoe_at[9], wrsel_at[9], dqm_at[9], sa_at[9]);
      end
      checks++; if (cmd_at[3] !== CMD_NOP || rv_at[6] !== 1'b0) begin errors++; $display("FAIL bus_wr_no_rd: cmd=%h rv=%b", cmd_at[3], rv_at[6]); end
      run_cycle();
      ld_req = 1'b0;
      checks++; if (lg_at[2] !== 1'b1 || bg_at[2] !== 1'b0) begin errors++; $display("FAIL arb_ld_next: lg=%b bg=%b, required 1/0", lg_at[2], bg_at[2]); end
      checks++; if (cmd_at[2] !== CMD_ACT || sba_at[2] !== 2'b00 || sa_at[2] !== 13'h0001) begin
         errors++; $display("FAIL ld_act: cmd=%h SBA=%b SA=%h, required 3/00/0001", cmd_at[2], sba_at[2], sa_at[2]);
      end
      checks++; if (cmd_at[9] !== CMD_WR || sa_at[9] !== 13'h0600 || sdoe_at[9] !== 1'b1 || wrsel_at[9] !== 1'b1 || dqm_at[9] !== 2'b01) begin
         errors++; $display("FAIL ld_wr: cmd=%h SA=%h SDOE=%b wr_sel=%b DQM=%b, required 4/0600/1/1/01",
                            cmd_at[9], sa_at[9], sdoe_at[9], wrsel_at[9], dqm_at[9]);
      end
      checks++; if (cmd_at[10] !== CMD_NOP || sdoe_at[10] !== 1'b0 || sa_at[10] !== 13'd0 || dqm_at[10] !== 2'b11) begin
         errors++; $display("FAIL ld_wr_end: cmd=%h SDOE=%b SA=%h DQM=%b", cmd_at[10], sdoe_at[10], sa_at[10], dqm_at[10]);
      end
   endtask

   task automatic test_phi0_ignore;
      int n_act;
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 24'h000000;
      rephi = 1'b1;
      run_cycle();
      rephi = 1'b0;
      n_act = 0;
      for (int i = 3; i < 16; i++) if (cmd_at[i] === CMD_ACT) n_act++;
      if (cmd_at[0] === CMD_ACT) n_act++;
      checks++; if (cmd_at[2] !== CMD_ACT) begin errors++; $display("FAIL phi_first_act: cmd=%h, required 3", cmd_at[2]); end
      for (int i = 0; i < 4; i++) begin
         @(negedge C25M);
         if (sd_cmd === CMD_ACT) n_act++;
         checks++;
         if (PS !== 4'd0) begin errors++; $display("FAIL phi_no_restart: PS=%0d, required 0", PS); end
      end
      checks++; if (n_act != 0) begin errors++; $display("FAIL phi_second_act: %0d, required 0", n_act); end
      bus_req = 1'b0;
      PHI0 = 1'b0;
      repeat (3) @(negedge C25M);
   endtask

   task automatic test_midwrite_reset;
      int n;
      ld_req = 1'b1; ld_addr = 24'h000400;
      PHI0 = 1'b1;
      n = 0;
      @(negedge C25M);
      while (PS !== 4'd1 && n < 8) begin @(negedge C25M); n++; end
      PHI0 = 1'b0;
      @(negedge C25M);
      checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL mr_ld_gnt: %b, required 1", ld_gnt); end
      ld_req = 1'b0;
      n = 0;
      while (PS !== 4'd8 && n < 16) begin @(negedge C25M); n++; end
      checks++; if (PS !== 4'd8) begin errors++; $display("FAIL mr_reach_ps8: PS=%0d, required 8", PS); end
      nRES = 1'b0;
      @(negedge C25M);
      checks++; if (sd_cmd !== CMD_NOP || SDOE !== 1'b0) begin errors++; $display("FAIL mr_abort: cmd=%h SDOE=%b, required F/0", sd_cmd, SDOE); end
      checks++; if (PS !== 4'd0 || init_done !== 1'b0) begin errors++; $display("FAIL mr_state: PS=%0d done=%b, required 0/0", PS, init_done); end
      nRES = 1'b1;
      repeat (2) @(negedge C25M);
      checks++; if (sd_cmd !== CMD_NOP || init_done !== 1'b0 || PS !== 4'd0) begin
         errors++; $display("FAIL mr_after: cmd=%h done=%b PS=%0d, required F/0/0", sd_cmd, init_done, PS);
      end
   endtask

   initial begin
      nRES = 1'b0; PHI0 = 1'b0; bus_req = 1'b0; bus_we = 1'b0; ld_req = 1'b0;
      bus_addr = 24'd0; ld_addr = 24'd0; SD = 8'h00; sd_drive = 8'h00; rephi = 1'b0;
      repeat (3) @(negedge C25M);
      test_reset();
      test_init();
      test_refresh();
      test_read();
      test_back_to_back();
      test_phi0_ignore();
      test_midwrite_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
